// File: rtl/dwt_pair_packer.sv
// dwt_pair_packer: packs raster samples into {odd, even} pairs, padding odd-length lines by symmetric extension.
// Optional macro PACK_CHECK_EN adds err_o, a sticky protocol error flag backed by a per-line sample counter.
module dwt_pair_packer #(
    parameter int DataWidth       = 16,
    parameter int MaximumSideSize = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [DataWidth-1:0]   s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o
`ifdef PACK_CHECK_EN
    ,
    output logic                   err_o
`endif
);
    typedef enum logic [1:0] {ST_EVEN, ST_ODD, ST_PAD} state_t;

    state_t                 state_q, state_d;
    logic [DataWidth-1:0]   hold_even_q, hold_even_d;
    logic [DataWidth-1:0]   last_odd_q, last_odd_d;
    logic                   hold_sof_q, hold_sof_d;
    logic                   last_odd_vld_q, last_odd_vld_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_sof_q, m_sof_d;
    logic                   m_eol_q, m_eol_d;
    logic [2*DataWidth-1:0] m_data_q, m_data_d;
    logic                   out_free;
    logic                   s_ready;
    logic                   s_fire;

    // Ready only ever depends on state and output register occupancy
    assign out_free  = !m_valid_q || m_ready_i;
    assign s_ready   = (state_q == ST_EVEN) || (state_q == ST_ODD && out_free);
    assign s_fire    = s_valid_i && s_ready;

    assign s_ready_o = s_ready;
    assign m_valid_o = m_valid_q;
    assign m_sof_o   = m_sof_q;
    assign m_eol_o   = m_eol_q;
    assign m_data_o  = m_data_q;

    // Pairing FSM: next state, held samples and output register load
    always_comb begin
        state_d        = state_q;
        hold_even_d    = hold_even_q;
        hold_sof_d     = hold_sof_q;
        last_odd_d     = last_odd_q;
        last_odd_vld_d = last_odd_vld_q;
        m_valid_d      = m_valid_q && !m_ready_i;
        m_sof_d        = m_sof_q;
        m_eol_d        = m_eol_q;
        m_data_d       = m_data_q;
        case (state_q)
            ST_EVEN: begin
                if (s_fire) begin
                    hold_even_d    = s_data_i;
                    hold_sof_d     = s_sof_i;
                    last_odd_vld_d = last_odd_vld_q && !s_sof_i;
                    state_d        = s_eol_i ? ST_PAD : ST_ODD;
                end
            end
            ST_ODD: begin
                if (s_fire && s_sof_i) begin
                    // Frame restarted mid-pair: drop the held even, the sof sample becomes the new even
                    hold_even_d    = s_data_i;
                    hold_sof_d     = 1'b1;
                    last_odd_vld_d = 1'b0;
                    state_d        = s_eol_i ? ST_PAD : ST_ODD;
                end else if (s_fire) begin
                    m_valid_d      = 1'b1;
                    m_data_d       = {s_data_i, hold_even_q};
                    m_sof_d        = hold_sof_q;
                    m_eol_d        = s_eol_i;
                    last_odd_d     = s_data_i;
                    last_odd_vld_d = !s_eol_i;
                    state_d        = ST_EVEN;
                end
            end
            ST_PAD: begin
                if (out_free) begin
                    // Mirror about the last even sample; a lone sample mirrors onto itself
                    m_valid_d      = 1'b1;
                    m_data_d       = {last_odd_vld_q ? last_odd_q : hold_even_q, hold_even_q};
                    m_sof_d        = hold_sof_q;
                    m_eol_d        = 1'b1;
                    last_odd_vld_d = 1'b0;
                    state_d        = ST_EVEN;
                end
            end
            default: state_d = ST_EVEN;
        endcase
    end

    // State and datapath registers; reset discards any partial pair
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_EVEN;
            hold_even_q    <= '0;
            hold_sof_q     <= 1'b0;
            last_odd_q     <= '0;
            last_odd_vld_q <= 1'b0;
            m_valid_q      <= 1'b0;
            m_sof_q        <= 1'b0;
            m_eol_q        <= 1'b0;
            m_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            hold_even_q    <= hold_even_d;
            hold_sof_q     <= hold_sof_d;
            last_odd_q     <= last_odd_d;
            last_odd_vld_q <= last_odd_vld_d;
            m_valid_q      <= m_valid_d;
            m_sof_q        <= m_sof_d;
            m_eol_q        <= m_eol_d;
            m_data_q       <= m_data_d;
        end
    end

`ifdef PACK_CHECK_EN
    localparam int CntWidth = $clog2(MaximumSideSize + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                pend_q, pend_d;

    // Per-line sample count and sticky protocol error detection
    always_comb begin
        cnt_d  = cnt_q;
        if (s_fire) begin
            cnt_d = s_eol_i ? '0 :
                    s_sof_i ? CntWidth'(1) :
                    (cnt_q == CntWidth'(MaximumSideSize)) ? cnt_q : cnt_q + 1'b1;
        end
        pend_d = s_valid_i && !s_ready;
        err_d  = err_q ||
                 (s_fire && s_sof_i && state_q == ST_ODD) ||
                 (s_fire && !s_eol_i && cnt_d == CntWidth'(MaximumSideSize)) ||
                 (pend_q && !s_valid_i);
    end

    // Checker registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    assign err_o = err_q;
`endif
endmodule

// File: tb/tb_dwt_pair_packer.sv
// tb_dwt_pair_packer: directed bench with a line-level pairing model and literal beat checks.
module tb_dwt_pair_packer;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          s_ready_o;
    logic          s_valid_i;
    logic          s_sof_i;
    logic          s_eol_i;
    logic [DW-1:0] s_data_i;
    logic          m_ready_i;
    logic          m_valid_o;
    logic          m_sof_o;
    logic          m_eol_o;
    logic [2*DW-1:0] m_data_o;
`ifdef PACK_CHECK_EN
    logic          err_o;
`endif

    dwt_pair_packer #(.DataWidth(DW), .MaximumSideSize(512)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .s_ready_o(s_ready_o),
        .s_valid_i(s_valid_i),
        .s_sof_i(s_sof_i),
        .s_eol_i(s_eol_i),
        .s_data_i(s_data_i),
        .m_ready_i(m_ready_i),
        .m_valid_o(m_valid_o),
        .m_sof_o(m_sof_o),
        .m_eol_o(m_eol_o),
        .m_data_o(m_data_o)
`ifdef PACK_CHECK_EN
        ,
        .err_o(err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2*DW-1:0] d;
        logic            sof;
        logic            eol;
    } beat_t;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    beat_t         exp_q[$];
    beat_t         got_q[$];
    int            got_cyc[$];
    logic [DW-1:0] line_d[$];
    logic          line_sof[$];
    logic          prev_hold = 1'b0;
    beat_t         prev_beat;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Line model: a line is the list of samples since the last sof/eol; pairs come from
    // consecutive index pairs, and an odd-length line mirrors x[N-2] (or x[N-1] if alone).
    function automatic void model_push(input logic [DW-1:0] d, input logic sof, input logic eol);
        int n;
        beat_t b;
        if (sof) begin
            line_d.delete();
            line_sof.delete();
        end
        line_d.push_back(d);
        line_sof.push_back(sof);
        n = line_d.size();
        if (n % 2 == 0) begin
            b.d = {line_d[n-1], line_d[n-2]};
            b.sof = line_sof[n-2];
            b.eol = eol;
            exp_q.push_back(b);
        end else if (eol) begin
            b.d = {(n > 1) ? line_d[n-2] : line_d[n-1], line_d[n-1]};
            b.sof = line_sof[n-1];
            b.eol = 1'b1;
            exp_q.push_back(b);
        end
        if (eol) begin
            line_d.delete();
            line_sof.delete();
        end
    endfunction

    always @(negedge clk_i) begin
        beat_t cur;
        cyc++;
        cur = {m_data_o, m_sof_o, m_eol_o};
        if (rst_i) begin
            exp_q.delete();
            line_d.delete();
            line_sof.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", m_valid_o, 1);
                chk("hold_beat", cur, prev_beat);
            end
            prev_hold = m_valid_o && !m_ready_i;
            prev_beat = cur;
            if (m_valid_o && m_ready_i) begin
                got_q.push_back(cur);
                got_cyc.push_back(cyc);
                chk("model_has_beat", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("model_beat", cur, exp_q.pop_front());
            end
            if (s_valid_i && s_ready_o) model_push(s_data_i, s_sof_i, s_eol_i);
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic sof, input logic eol);
        int n;
        n = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_sof_i   = sof;
        s_eol_i   = eol;
        @(negedge clk_i);
        while (!s_ready_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 100) chk("send_timeout", n, 0);
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    task automatic lit(input string nm, input int idx, input logic [2*DW-1:0] d, input logic sof, input logic eol);
        beat_t e;
        e = {d, sof, eol};
        if (idx < got_q.size()) chk(nm, got_q[idx], e);
        else chk({nm, "_missing"}, got_q.size(), idx + 1);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        s_valid_i = 1'b0;
        s_sof_i = 1'b0;
        s_eol_i = 1'b0;
        s_data_i = '0;
        m_ready_i = 1'b1;
        #1;
        chk("rst_valid", m_valid_o, 0);
        chk("rst_sof", m_sof_o, 0);
        chk("rst_eol", m_eol_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_ready", s_ready_o, 1);
`ifdef PACK_CHECK_EN
        chk("rst_err", err_o, 0);
`endif
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Even-length line
        clear_log();
        send(1, 1, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 1);
        drain();
        chk("even_count", got_q.size(), 2);
        lit("even_b0", 0, {16'd2, 16'd1}, 1, 0);
        lit("even_b1", 1, {16'd4, 16'd3}, 0, 1);
        if (got_cyc.size() >= 2) chk("even_gap", got_cyc[1] - got_cyc[0], 2);

        // Odd-length line with pad
        clear_log();
        send(10, 1, 0); send(20, 0, 0); send(30, 0, 1);
        chk("pad_ready_low", s_ready_o, 0);
        @(posedge clk_i);
        #1;
        chk("pad_ready_back", s_ready_o, 1);
        drain();
        chk("odd_count", got_q.size(), 2);
        lit("odd_b0", 0, {16'd20, 16'd10}, 1, 0);
        lit("odd_b1", 1, {16'd20, 16'd30}, 0, 1);

        // Single-sample line
        clear_log();
        send(7, 1, 1);
        drain();
        chk("single_count", got_q.size(), 1);
        lit("single_b0", 0, {16'd7, 16'd7}, 1, 1);

        // Backpressure during a 6-sample line
        clear_log();
        fork
            begin
                send(11, 1, 0); send(12, 0, 0); send(13, 0, 0);
                send(14, 0, 0); send(15, 0, 0); send(16, 0, 1);
            end
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                #1;
                m_ready_i = 1'b0;
                @(posedge clk_i);
                #1;
                chk("bp_ready_low", s_ready_o, 0);
                chk("bp_valid_high", m_valid_o, 1);
                repeat (4) @(posedge clk_i);
                #1;
                m_ready_i = 1'b1;
            end
        join
        drain();
        chk("bp_count", got_q.size(), 3);
        lit("bp_b0", 0, {16'd12, 16'd11}, 1, 0);
        lit("bp_b1", 1, {16'd14, 16'd13}, 0, 0);
        lit("bp_b2", 2, {16'd16, 16'd15}, 0, 1);

        // Mid-pair sof
`ifdef PACK_CHECK_EN
        chk("err_before_midsof", err_o, 0);
`endif
        clear_log();
        send(1, 1, 0); send(2, 0, 0); send(3, 0, 0);
        send(4, 1, 0); send(5, 0, 0); send(6, 0, 1);
        drain();
        chk("midsof_count", got_q.size(), 3);
        lit("midsof_b0", 0, {16'd2, 16'd1}, 1, 0);
        lit("midsof_b1", 1, {16'd5, 16'd4}, 1, 0);
        lit("midsof_b2", 2, {16'd5, 16'd6}, 0, 1);
`ifdef PACK_CHECK_EN
        chk("err_midsof", err_o, 1);
`endif

        // Asynchronous reset mid-line with a full output register
        clear_log();
        m_ready_i = 1'b0;
        send(21, 1, 0); send(22, 0, 0); send(23, 0, 0);
        chk("prerst_valid", m_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_valid", m_valid_o, 0);
        chk("rst_async_data", m_data_o, 0);
`ifdef PACK_CHECK_EN
        chk("rst_async_err", err_o, 0);
`endif
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_ready_i = 1'b1;
        send(8, 0, 0); send(9, 0, 1);
        drain();
        chk("after_rst_count", got_q.size(), 1);
        lit("after_rst_b0", 0, {16'd9, 16'd8}, 0, 1);

        chk("model_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dwt_pair_packer.md
Name: dwt_pair_packer

Overview:
- Upstream feeder of the 1D lifting processing unit.
- Takes one sample per beat in raster order, with sof/eol framing.
- Packs consecutive even/odd sample pairs into {odd, even} beats.
- For odd-length lines, appends a symmetric-extension pad sample so every line ends on a full pair.

Parameters:
- DataWidth, 16, sample width in bits (signed fixed point, passed through unchanged).
- MaximumSideSize, 512, maximum line length in samples; sizes the length counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_ready_o  out  1  input handshake ready
- s_valid_i  in  1  input handshake valid
- s_sof_i  in  1  first sample of frame
- s_eol_i  in  1  last sample of line
- s_data_i  in  DataWidth  input sample
- m_ready_i  in  1  output handshake ready
- m_valid_o  out  1  output handshake valid
- m_sof_o  out  1  first pair of frame
- m_eol_o  out  1  last pair of line
- m_data_o  out  2*DataWidth  {odd, even}; even in [DataWidth-1:0]
- err_o  out  1  sticky protocol error (only with PACK_CHECK_EN)

Behaviour:
- Reset: clk_i only; rst_i is asynchronous and active-high. While rst_i is high: state=EVEN, m_valid_o=0, m_sof_o=0, m_eol_o=0, m_data_o=0, held registers=0, err_o=0. Reset mid-line discards all partial data; the first beat after reset is treated as an even sample.
- Transfers: input on s_valid_i&s_ready_o; output on m_valid_o&m_ready_i. Once m_valid_o is high, it and the output data hold until accepted.
- out_free = !m_valid_o | m_ready_i.
- FSM states:
  - EVEN: waiting for an even-index sample. s_ready_o=1.
    - Accept without eol: hold_even<=data, hold_sof<=s_sof_i, go ODD.
    - Accept with eol (odd-length line): hold_even<=data, hold_sof<=s_sof_i, go PAD.
  - ODD: waiting for an odd-index sample. s_ready_o=out_free.
    - Accept: load output reg {data, hold_even}, m_sof_o=hold_sof, m_eol_o=s_eol_i; last_odd<=data.
    - Then go EVEN if s_eol_i, else EVEN as well (next pair starts). The eol only affects the pad source reset.
    - On eol, last_odd validity is cleared.
  - PAD: s_ready_o=0. When out_free: load {pad, hold_even}, m_sof_o=hold_sof, m_eol_o=1, go EVEN.
    - pad = last_odd if a previous odd sample exists in this line (x[N]=x[N-2]).
    - pad = hold_even for a 1-sample line.
- Latency: a pair is visible on m_* the cycle after its odd sample (or pad condition) is registered.
- Throughput: one pair per two input beats, with no bubbles when m_ready_i=1.
- s_ready_o depends only on state and output register status, never on s_valid_i or s_data_i.
- sof arriving while in ODD (frame restarts mid-pair): the held even sample is dropped and the sof sample becomes the new hold_even; state stays ODD. With PACK_CHECK_EN this also sets err_o.
- last_odd validity is cleared on every eol and every sof.
- Data is not modified; no arithmetic on samples.

Optional Feature:
- Macro PACK_CHECK_EN.
- Defined:
  - Adds err_o and a $clog2(MaximumSideSize+1)-bit sample counter. The counter resets on eol, sof and rst_i.
  - err_o sets (sticky until rst_i) on any of:
    - sof received in ODD state;
    - counter reaching MaximumSideSize without eol;
    - s_valid_i dropped while s_valid_i&!s_ready_o (valid withdrawn before handshake).
  - Data flow is unaffected by errors.
- Undefined: no counter, no err_o port; behaviour otherwise identical.

Test Plan:
- Even line, m_ready_i=1: samples 1,2,3,4 (sof on 1, eol on 4) -> two beats {2,1} sof=1 eol=0, then {4,3} sof=0 eol=1; no gap between pairs.
- Odd line: 10,20,30 (sof on 10, eol on 30) -> {20,10} sof=1, then pad beat {20,30} eol=1; s_ready_o=0 for exactly the PAD cycle(s).
- Single-sample line: 7 with sof+eol -> one beat {7,7} sof=1 eol=1.
- Backpressure: m_ready_i=0 for 5 cycles during a 6-sample line -> s_ready_o=0 in ODD while the output is full; m_data_o stable; all 3 pairs delivered in order, none lost or duplicated.
- Mid-pair sof: 1(sof),2,3,4(sof),5,6(eol) -> pairs {2,1},{5,4} sof=1,{6,?}… exactly {2,1} then {5,4} sof=1, then 6 with eol padded {5,6}; sample 3 dropped; err_o=1 with PACK_CHECK_EN.
- Reset mid-line: assert rst_i asynchronously while in ODD with m_valid_o=1 -> m_valid_o=0 immediately; the next line 8,9(eol) yields {9,8} eol=1.
